// File: rtl/alu_acc_core.sv
// Parametrised accumulator ALU with register file, C/Z/N/V flags and a shift-add multiplier.
// Optional build macro ALU_SAT_EN: ADD/SUB/ADC/SBB saturate on signed overflow.
module alu_acc_core #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RF_DEPTH = 4,
  localparam int unsigned RF_AW   = $clog2(RF_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_op,
  input  logic              i_src_sel,
  input  logic [RF_AW-1:0]  i_rf_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_alu,
  output logic [DATA_W-1:0] o_acc,
  output logic [DATA_W-1:0] o_rf_data,
  output logic [DATA_W-1:0] o_mul_hi,
  output logic              o_carry,
  output logic              o_zero,
  output logic              o_neg,
  output logic              o_ovf,
  output logic              o_done
);

  localparam int unsigned Msb  = DATA_W - 1;
  localparam int unsigned CntW = $clog2(DATA_W);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpNot = 4'd5;
  localparam logic [3:0] OpLd  = 4'd6;
  localparam logic [3:0] OpAdc = 4'd7;
  localparam logic [3:0] OpSbb = 4'd8;
  localparam logic [3:0] OpShl = 4'd9;
  localparam logic [3:0] OpShr = 4'd10;
  localparam logic [3:0] OpRol = 4'd11;
  localparam logic [3:0] OpMul = 4'd12;
  localparam logic [3:0] OpSt  = 4'd13;
  localparam logic [3:0] OpLdi = 4'd14;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StMul  = 1'b1;

  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   mul_hi_q, mul_hi_d;
  logic                c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
  logic [0:0]          state_q, state_d;
  logic                done_q, done_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   rf_q [RF_DEPTH];
  logic                rf_we;

  logic [DATA_W-1:0]   opb;
  logic [DATA_W:0]     add_full, sub_full;
  logic                add_ovf, sub_ovf;
  logic [DATA_W-1:0]   sat_val;
  logic [DATA_W-1:0]   res;
  logic                res_c, res_v, res_wr;
  logic [DATA_W:0]     hi_sum;
  logic [2*DATA_W-1:0] prod_next;
  logic                mul_last;

  assign opb = i_src_sel ? i_mem_data : rf_q[i_rf_addr];

  assign add_full = {1'b0, acc_q} + {1'b0, opb} + (DATA_W+1)'((i_op == OpAdc) & c_q);
  assign sub_full = {1'b0, acc_q} - {1'b0, opb} - (DATA_W+1)'((i_op == OpSbb) & c_q);
  assign add_ovf  = (acc_q[Msb] == opb[Msb]) && (add_full[Msb] != acc_q[Msb]);
  assign sub_ovf  = (acc_q[Msb] != opb[Msb]) && (sub_full[Msb] != acc_q[Msb]);
  // Overflow direction always follows the sign of A for both add and subtract.
  assign sat_val  = acc_q[Msb] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};

  always_comb begin
    res    = acc_q;
    res_c  = c_q;
    res_v  = v_q;
    res_wr = 1'b1;
    case (i_op)
      OpAdd, OpAdc: begin
        res   = add_full[DATA_W-1:0];
        res_c = add_full[DATA_W];
        res_v = add_ovf;
`ifdef ALU_SAT_EN
        if (add_ovf) res = sat_val;
`endif
      end
      OpSub, OpSbb: begin
        res   = sub_full[DATA_W-1:0];
        res_c = sub_full[DATA_W];
        res_v = sub_ovf;
`ifdef ALU_SAT_EN
        if (sub_ovf) res = sat_val;
`endif
      end
      OpAnd: begin res = acc_q & opb; res_c = 1'b0; res_v = 1'b0; end
      OpOr:  begin res = acc_q | opb; res_c = 1'b0; res_v = 1'b0; end
      OpXor: begin res = acc_q ^ opb; res_c = 1'b0; res_v = 1'b0; end
      OpNot: begin res = ~opb;        res_c = 1'b0; res_v = 1'b0; end
      OpLd:  res = opb;
      OpLdi: res = i_imm;
      OpShl: begin res = {acc_q[Msb-1:0], 1'b0}; res_c = acc_q[Msb]; res_v = 1'b0; end
      OpShr: begin res = {1'b0, acc_q[Msb:1]};   res_c = acc_q[0];   res_v = 1'b0; end
      OpRol: begin res = {acc_q[Msb-1:0], c_q};  res_c = acc_q[Msb]; res_v = 1'b0; end
      default: res_wr = 1'b0;
    endcase
  end

  // Right-shifting shift-add: low half starts as the multiplier and drains out as product bits.
  assign hi_sum    = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_next = {hi_sum, prod_q[DATA_W-1:1]};
  assign mul_last  = (cnt_q == CntW'(DATA_W - 1));

  always_comb begin
    acc_d    = acc_q;
    mul_hi_d = mul_hi_q;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    state_d  = state_q;
    done_d   = 1'b0;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    rf_we    = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_valid) begin
          if (i_op == OpMul) begin
            state_d = StMul;
            mcand_d = acc_q;
            prod_d  = {{DATA_W{1'b0}}, opb};
            cnt_d   = '0;
          end else if (i_op == OpSt) begin
            rf_we = 1'b1;
          end else if (res_wr) begin
            acc_d = res;
            c_d   = res_c;
            v_d   = res_v;
            z_d   = (res == '0);
            n_d   = res[Msb];
          end
        end
      end
      StMul: begin
        prod_d = prod_next;
        cnt_d  = cnt_q + CntW'(1);
        if (mul_last) begin
          state_d  = StIdle;
          acc_d    = prod_next[DATA_W-1:0];
          mul_hi_d = prod_next[2*DATA_W-1:DATA_W];
          c_d      = |prod_next[2*DATA_W-1:DATA_W];
          v_d      = 1'b0;
          z_d      = (prod_next == '0);
          n_d      = prod_next[Msb];
          done_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q    <= '0;
      mul_hi_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      state_q  <= StIdle;
      done_q   <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mul_hi_q <= mul_hi_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      state_q  <= state_d;
      done_q   <= done_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[i_rf_addr] <= acc_q;
    end
  end

  assign o_ready   = (state_q == StIdle);
  assign o_alu     = res;
  assign o_acc     = acc_q;
  assign o_rf_data = rf_q[i_rf_addr];
  assign o_mul_hi  = mul_hi_q;
  assign o_carry   = c_q;
  assign o_zero    = z_q;
  assign o_neg     = n_q;
  assign o_ovf     = v_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_alu_acc_core.sv
// Randomised bench for alu_acc_core against an arithmetic reference model, plus pinned scenarios.
module tb_alu_acc_core;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned RF_DEPTH = 4;
  localparam int unsigned RF_AW    = 2;
  localparam int Mask = (1 << DATA_W) - 1;
  localparam int Smax = (1 << (DATA_W - 1)) - 1;
  localparam int Smin = -(1 << (DATA_W - 1));

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [3:0]        i_op = 4'd15;
  logic              i_src_sel = 1'b0;
  logic [RF_AW-1:0]  i_rf_addr = '0;
  logic [DATA_W-1:0] i_mem_data = '0;
  logic [DATA_W-1:0] i_imm = '0;
  logic [DATA_W-1:0] o_alu, o_acc, o_rf_data, o_mul_hi;
  logic              o_carry, o_zero, o_neg, o_ovf, o_done;

  alu_acc_core #(.DATA_W(DATA_W), .RF_DEPTH(RF_DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_src_sel(i_src_sel), .i_rf_addr(i_rf_addr), .i_mem_data(i_mem_data), .i_imm(i_imm),
    .o_alu(o_alu), .o_acc(o_acc), .o_rf_data(o_rf_data), .o_mul_hi(o_mul_hi),
    .o_carry(o_carry), .o_zero(o_zero), .o_neg(o_neg), .o_ovf(o_ovf), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  // Reference model state
  int m_acc, m_hi, m_busy, m_prod;
  int m_rf [RF_DEPTH];
  bit m_c, m_z, m_n, m_v, m_done;

  int n_vec = 0, n_cmp = 0, n_err = 0, n_done = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int x);
    return (x & (1 << (DATA_W - 1))) != 0 ? x - (1 << DATA_W) : x;
  endfunction

  function automatic void model_alu(input int op, input int a, input int b, input int imm,
                                    input bit cin, input bit vin,
                                    output int res, output bit c, output bit v, output bit wr);
    int full, s, ci;
    res = a; c = cin; v = vin; wr = 1'b1;
    ci = ((op == 7 || op == 8) && cin) ? 1 : 0;
    case (op)
      0, 7: begin
        full = a + b + ci; s = sx(a) + sx(b) + ci;
        res = full & Mask; c = full > Mask; v = (s > Smax) || (s < Smin);
`ifdef ALU_SAT_EN
        if (v) res = (s > Smax) ? Smax : (Smin & Mask);
`endif
      end
      1, 8: begin
        full = a - b - ci; s = sx(a) - sx(b) - ci;
        res = full & Mask; c = full < 0; v = (s > Smax) || (s < Smin);
`ifdef ALU_SAT_EN
        if (v) res = (s > Smax) ? Smax : (Smin & Mask);
`endif
      end
      2:  begin res = a & b; c = 0; v = 0; end
      3:  begin res = a | b; c = 0; v = 0; end
      4:  begin res = a ^ b; c = 0; v = 0; end
      5:  begin res = ~b & Mask; c = 0; v = 0; end
      6:  res = b;
      14: res = imm;
      9:  begin res = (a << 1) & Mask; c = ((a >> (DATA_W - 1)) & 1) != 0; v = 0; end
      10: begin res = a >> 1; c = (a & 1) != 0; v = 0; end
      11: begin res = ((a << 1) | int'(cin)) & Mask; c = ((a >> (DATA_W - 1)) & 1) != 0; v = 0; end
      default: wr = 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_acc = 0; m_hi = 0; m_busy = 0; m_prod = 0;
    m_c = 0; m_z = 0; m_n = 0; m_v = 0; m_done = 0;
    for (int i = 0; i < RF_DEPTH; i++) m_rf[i] = 0;
  endtask

  // Advance one clock: the model applies the edge, then control returns just after the falling edge.
  task automatic tick();
    int b, res;
    bit c, v, wr;
    @(posedge i_clk);
    if (i_rst) model_reset();
    else begin
      m_done = 0;
      b = i_src_sel ? int'(i_mem_data) : m_rf[i_rf_addr];
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_acc = m_prod & Mask; m_hi = m_prod >> DATA_W;
          m_c = m_hi != 0; m_v = 0; m_z = m_prod == 0;
          m_n = ((m_acc >> (DATA_W - 1)) & 1) != 0; m_done = 1;
        end
      end else if (i_valid) begin
        if (i_op == 4'd12) begin
          m_busy = DATA_W; m_prod = m_acc * b;
        end else if (i_op == 4'd13) begin
          m_rf[i_rf_addr] = m_acc;
        end else begin
          model_alu(int'(i_op), m_acc, b, int'(i_imm), m_c, m_v, res, c, v, wr);
          if (wr) begin
            m_acc = res; m_c = c; m_v = v; m_z = res == 0;
            m_n = ((res >> (DATA_W - 1)) & 1) != 0;
          end
        end
      end
    end
    n_vec++;
    @(negedge i_clk);
    #1;
    if (o_done) n_done++;
  endtask

  // Every-cycle comparison against the model
  always @(negedge i_clk) begin
    int b, res;
    bit c, v, wr;
    chk("acc", int'(o_acc), m_acc);
    chk("mul_hi", int'(o_mul_hi), m_hi);
    chk("carry", int'(o_carry), int'(m_c));
    chk("zero", int'(o_zero), int'(m_z));
    chk("neg", int'(o_neg), int'(m_n));
    chk("ovf", int'(o_ovf), int'(m_v));
    chk("ready", int'(o_ready), int'(m_busy == 0));
    chk("done", int'(o_done), int'(m_done));
    chk("rf_data", int'(o_rf_data), m_rf[i_rf_addr]);
    if (m_busy == 0 && !i_rst) begin
      b = i_src_sel ? int'(i_mem_data) : m_rf[i_rf_addr];
      model_alu(int'(i_op), m_acc, b, int'(i_imm), m_c, m_v, res, c, v, wr);
      if (wr) chk("alu", int'(o_alu), res);
    end
  end

  task automatic issue(input int op, input bit src, input int addr, input int mem, input int imm);
    i_op = 4'(op); i_src_sel = src; i_rf_addr = RF_AW'(addr);
    i_mem_data = DATA_W'(mem); i_imm = DATA_W'(imm); i_valid = 1'b1;
    tick();
    i_valid = 1'b0; i_op = 4'd15;
  endtask

  initial begin
    int ready_low, done_before;
    model_reset();
    tick(); tick();
    chk("reset_acc", int'(o_acc), 0);
    chk("reset_ready", int'(o_ready), 1);
    chk("reset_flags", int'({o_carry, o_zero, o_neg, o_ovf, o_done}), 0);
    i_rst = 1'b0;
    tick();

    // Signed overflow on add
    issue(14, 0, 0, 0, 'h7F);
    issue(0, 1, 0, 'h01, 0);
`ifdef ALU_SAT_EN
    chk("ovf_add_acc", int'(o_acc), 'h7F);
    chk("ovf_add_czn_v", int'({o_carry, o_zero, o_neg, o_ovf}), 'b0001);
`else
    chk("ovf_add_acc", int'(o_acc), 'h80);
    chk("ovf_add_czn_v", int'({o_carry, o_zero, o_neg, o_ovf}), 'b0011);
`endif
    issue(14, 0, 0, 0, 'h80);
    issue(1, 1, 0, 'h01, 0);
`ifdef ALU_SAT_EN
    chk("ovf_sub_acc", int'(o_acc), 'h80);
`else
    chk("ovf_sub_acc", int'(o_acc), 'h7F);
`endif
    chk("ovf_sub_v", int'(o_ovf), 1);

    // Carry out then carry in
    issue(14, 0, 0, 0, 'hFF);
    issue(0, 1, 0, 'h01, 0);
    chk("carry_acc", int'(o_acc), 'h00);
    chk("carry_cz", int'({o_carry, o_zero}), 'b11);
    issue(7, 1, 0, 'h00, 0);
    chk("adc_acc", int'(o_acc), 'h01);
    chk("adc_cz", int'({o_carry, o_zero}), 'b00);

    // Register file store/load
    issue(14, 0, 0, 0, 'h0D);
    i_rf_addr = 2'd2; #1;
    chk("rf_before_st", int'(o_rf_data), 0);
    issue(13, 0, 2, 0, 0);
    chk("rf_after_st", int'(o_rf_data), 'h0D);
    issue(14, 0, 0, 0, 'h00);
    issue(6, 0, 2, 0, 0);
    chk("ld_rf_acc", int'(o_acc), 'h0D);
    i_rf_addr = 2'd1; #1;
    chk("rf1_untouched", int'(o_rf_data), 0);

    // Multiply with an ADD presented while busy
    issue(14, 0, 0, 0, 'hC8);
    done_before = n_done;
    issue(12, 1, 0, 'h03, 0);
    ready_low = 0;
    i_op = 4'd0; i_src_sel = 1'b1; i_mem_data = 8'h01; i_valid = 1'b1;
    for (int k = 0; k < 20 && !o_ready; k++) begin
      ready_low++;
      tick();
    end
    i_valid = 1'b0; i_op = 4'd15;
    chk("mul_ready_low", ready_low, DATA_W);
    chk("mul_acc", int'(o_acc), 'h58);
    chk("mul_hi", int'(o_mul_hi), 'h02);
    chk("mul_carry", int'(o_carry), 1);
    tick();
    chk("mul_done_pulses", n_done - done_before, 1);

    // Reset during multiply
    issue(14, 0, 0, 0, 'h05);
    done_before = n_done;
    issue(12, 1, 0, 'h07, 0);
    for (int k = 0; k < 4; k++) tick();
    i_rst = 1'b1; model_reset(); #1;
    chk("abort_acc", int'(o_acc), 0);
    chk("abort_hi", int'(o_mul_hi), 0);
    tick();
    i_rst = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("abort_ready", int'(o_ready), 1);
    chk("abort_flags", int'({o_carry, o_zero, o_neg, o_ovf}), 0);
    chk("abort_no_done", n_done - done_before, 0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      i_op       = 4'($urandom_range(0, 15));
      i_valid    = ($urandom_range(0, 9) < 8);
      i_src_sel  = 1'($urandom);
      i_rf_addr  = RF_AW'($urandom);
      i_mem_data = DATA_W'($urandom);
      i_imm      = DATA_W'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        i_rst = 1'b1; model_reset();
        tick();
        i_rst = 1'b0;
      end else begin
        tick();
      end
    end
    i_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_acc_core.md
Name: alu_acc_core

Overview:
Parametrised accumulator ALU core. It is the successor to the 8-bit accumulator/ALU datapath and adds configurable data width and register-file depth, real carry/zero/negative/overflow flags, carry-chained and shift ops, and a multi-cycle shift-add multiplier with a valid/ready handshake. It sits between the control unit (opcode issue), the data memory read port and the immediate field of the instruction decoder.

Parameters:
DATA_W, 8, datapath width in bits (min 4).
RF_DEPTH, 4, number of general registers (power of 2, min 2); derived localparam RF_AW = $clog2(RF_DEPTH).

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_valid  input  1  operation request
o_ready  output  1  core can accept; low while multiply in progress
i_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 LD, 7 ADC, 8 SBB, 9 SHL, 10 SHR, 11 ROL, 12 MUL, 13 ST, 14 LDI, 15 NOP
i_src_sel  input  1  operand B source: 0 = RF[i_rf_addr], 1 = i_mem_data
i_rf_addr  input  RF_AW  register read/write address
i_mem_data  input  DATA_W  data memory read data
i_imm  input  DATA_W  immediate for LDI
o_alu  output  DATA_W  combinational result of current i_op/operands
o_acc  output  DATA_W  accumulator
o_rf_data  output  DATA_W  RF[i_rf_addr], combinational read
o_mul_hi  output  DATA_W  upper half of last product
o_carry, o_zero, o_neg, o_ovf  output  1 each  registered flags C, Z, N, V
o_done  output  1  one-cycle pulse when a MUL result is written

Behaviour:
- Reset: acc, all RF entries, o_mul_hi, flags = 0; FSM = IDLE; o_ready = 1; o_done = 0.
- Accept = i_valid && o_ready on a rising edge. i_valid while o_ready = 0 is ignored, with no side effects.
- Single-cycle ops: acc and flags update on the accept edge. B = selected operand, A = acc.
- ADD/ADC: A+B(+C). SUB/SBB: A-B(-C), C = borrow. V = signed overflow.
- AND/OR/XOR/NOT (NOT = ~B): C = 0, V = 0.
- SHL/SHR: shift A by 1 and fill with 0; C = bit shifted out; V = 0.
- ROL: rotate A left through C.
- LD: acc <= B. LDI: acc <= i_imm. Both: C and V unchanged.
- All acc-writing ops: Z = (result == 0), N = result MSB.
- ST: RF[i_rf_addr] <= acc; acc and flags unchanged. NOP: no change.
- RF write is visible on o_rf_data the cycle after the edge. A same-cycle read returns the old value.
- MUL (unsigned): FSM IDLE -> MUL on accept. A and B are latched and the counter is cleared.
  - One shift-add iteration per cycle for DATA_W cycles; o_ready = 0 from the accept edge through edge DATA_W.
  - At edge DATA_W: acc <= product low half, o_mul_hi <= high half, C = (high != 0), V = 0, Z = (full 2*DATA_W product == 0), N = low MSB. FSM -> IDLE, o_ready = 1, o_done = 1 for that following cycle only.
  - Inputs are not sampled during MUL.
- Reset asserted mid-MUL aborts immediately: no partial result is written and all state returns to reset values.
- ADC/SBB with C from a previous MUL use that C as-is.

Optional Feature:
ALU_SAT_EN: when defined, ADD/SUB/ADC/SBB saturate on signed overflow. Result clamps to the signed max (0x7F at DATA_W=8) or signed min (0x80); V = 1; C is still the raw carry/borrow. When undefined, results wrap modulo 2^DATA_W. All other ops are identical in both builds.

Test Plan:
- Reset; LDI 0x7F; ADD src=mem, mem=0x01 -> acc 0x80, N=1, V=1, C=0, Z=0 (macro off).
- LDI 0xFF; ADD mem 0x01 -> acc 0x00, C=1, Z=1; then ADC mem 0x00 -> acc 0x01, C=0, Z=0.
- LDI 0x0D; ST addr2; LDI 0x00; LD src=RF addr2 -> acc 0x0D; o_rf_data at addr2 = 0x0D one cycle after ST; RF[1] stays 0.
- LDI 0xC8; MUL mem 0x03 -> o_ready low 8 cycles; acc 0x58, o_mul_hi 0x02, C=1, single o_done pulse; ADD presented mid-MUL ignored (acc unchanged at completion).
- Start MUL; assert i_rst at iteration 4 -> acc 0, o_mul_hi 0, flags 0, o_done never pulses, o_ready 1 after release.
- With ALU_SAT_EN: LDI 0x7F; ADD mem 0x01 -> acc 0x7F, V=1. LDI 0x80; SUB mem 0x01 -> acc 0x80, V=1.
